down_counter_scheduler: RTL and testbench

//   Shares one programmable 4-bit-style MOD-(L+1) down counter between NUM_REQ

---
 rtl/down_counter_scheduler_if.sv | 32 +++
 rtl/down_counter_scheduler.sv | 129 ++++++++++++
 tb/tb_down_counter_scheduler.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/down_counter_scheduler_if.sv
// Request/grant bundle between timing clients and the shared countdown block.
//
// Ports (all carried as interface signals):
//   req       per-requester request level, held high until done
//   load_val  packed load values, slice i = [i*CNT_W +: CNT_W]
//   grant     one-hot owner of the counter, 0 when unowned
//   busy      high whenever the scheduler is not idle
//   count     current counter value
//   done      one-cycle one-hot completion pulse
//
// Modports: master = requester side, slave = scheduler side.
interface down_counter_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] load_val;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [CNT_W-1:0]         count;
  logic [NUM_REQ-1:0]       done;

  modport master (
    output req, load_val,
    input  grant, busy, count, done
  );

  modport slave (
    input  req, load_val,
    output grant, busy, count, done
  );
endinterface

// File: rtl/down_counter_scheduler.sv
// Shares one programmable MOD-(L+1) down counter between NUM_REQ requesters.
// Requesters are served round-robin; the winner's load value is captured,
// counted down to 0 and a one-cycle done pulse is returned to the owner.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   down_counter_scheduler_if.slave (req, load_val in; grant, busy,
//         count, done out). All outputs are registered.
module down_counter_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
) (
  input logic                     clk,
  input logic                     rst,
  down_counter_scheduler_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t             state;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic [CNT_W-1:0]   count_q;
  logic               busy_q;
  logic [IDX_W-1:0]   last_idx;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] win_onehot;
  logic [CNT_W-1:0]   win_load;
  logic               owner_req;

  // Round-robin search: start at the index after the last grant and take
  // the first active request, wrapping NUM_REQ-1 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_idx;
    cand      = last_idx;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_idx) + k) % NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Decode the winner into its one-hot grant and select its load value.
  always_comb begin
    win_onehot = '0;
    win_load   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_onehot[i] = 1'b1;
        win_load      = bus.load_val[i*CNT_W +: CNT_W];
      end
    end
  end

  // The owner is still interested as long as its own request bit is high.
  assign owner_req = |(bus.req & grant_q);

  // Scheduler FSM. The pointer is updated at grant time, so an aborted job
  // still moves priority on to the next requester. Abort wins over the
  // count reaching zero in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      last_idx <= IDX_W'(NUM_REQ - 1);
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= COUNT;
            grant_q  <= win_onehot;
            count_q  <= win_load;
            busy_q   <= 1'b1;
            last_idx <= win_idx;
          end
        end
        COUNT: begin
          if (!owner_req) begin
            state   <= IDLE;
            grant_q <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
          end else if (count_q == '0) begin
            state   <= DONE;
            done_q  <= grant_q;
            grant_q <= '0;
            busy_q  <= 1'b1;
          end else begin
            count_q <= count_q - CNT_W'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          count_q <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          count_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.count = count_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_down_counter_scheduler.sv
// Self-checking bench for down_counter_scheduler: directed scenarios with
// literal expectations, then randomized traffic against a job-level model.
module tb_down_counter_scheduler;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  down_counter_scheduler_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

  down_counter_scheduler #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Job-level model: who owns the counter, what is left on it, who is
  // being told "done" this cycle, and who was granted last.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_done  = -1;
  int m_last  = NUM_REQ - 1;

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    onehot = '0;
    if (i >= 0) onehot[i] = 1'b1;
  endfunction

  task automatic expectValue(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sees.
  task automatic modelStep();
    if (rst) begin
      m_owner = -1;
      m_cnt   = 0;
      m_done  = -1;
      m_last  = NUM_REQ - 1;
    end else if (m_done >= 0) begin
      m_done = -1;
    end else if (m_owner >= 0) begin
      if (!bus.req[m_owner]) begin
        m_owner = -1;
        m_cnt   = 0;
      end else if (m_cnt == 0) begin
        m_done  = m_owner;
        m_owner = -1;
      end else begin
        m_cnt--;
      end
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int i;
        i = (m_last + k) % NUM_REQ;
        if (m_owner < 0 && bus.req[i]) begin
          m_owner = i;
          m_cnt   = int'(bus.load_val[i*CNT_W +: CNT_W]);
          m_last  = i;
        end
      end
    end
  endtask

  task automatic checkOutput();
    expectValue("grant", int'(bus.grant), int'(onehot(m_owner)));
    expectValue("count", int'(bus.count), (m_owner >= 0) ? m_cnt : 0);
    expectValue("done",  int'(bus.done),  int'(onehot(m_done)));
    expectValue("busy",  int'(bus.busy),  (m_owner >= 0 || m_done >= 0) ? 1 : 0);
    expectValue("grant_done_excl", int'((|bus.grant) && (|bus.done)), 0);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*CNT_W-1:0] lv);
    bus.req      = r;
    bus.load_val = lv;
  endtask

  task automatic setLoad(input int i, input int v);
    logic [NUM_REQ*CNT_W-1:0] lv;
    lv = bus.load_val;
    lv[i*CNT_W +: CNT_W] = CNT_W'(v);
    bus.load_val = lv;
  endtask

  // Random requester behaviour: mostly well-behaved (hold until done, then
  // drop), with occasional aborts, hold-through-done and resets.
  task automatic randomDrive();
    logic [NUM_REQ-1:0]       r;
    logic [NUM_REQ*CNT_W-1:0] lv;
    r  = bus.req;
    lv = bus.load_val;
    rst = ($urandom_range(0, 199) == 0);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (m_done == i) begin
        if ($urandom_range(0, 7) != 0) r[i] = 1'b0;
      end else if (!r[i]) begin
        if ($urandom_range(0, 3) == 0) r[i] = 1'b1;
      end else if (i == m_owner) begin
        if ($urandom_range(0, 39) == 0) r[i] = 1'b0;
      end else if ($urandom_range(0, 29) == 0) begin
        r[i] = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) lv[i*CNT_W +: CNT_W] = CNT_W'($urandom);
    end
    applyStimulus(r, lv);
  endtask

  initial begin
    logic [NUM_REQ-1:0] t2_exp [5];
    t2_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst = 1'b1;
    applyStimulus('0, '0);
    stepCycle();
    expectValue("rst_grant", int'(bus.grant), 0);
    expectValue("rst_busy",  int'(bus.busy),  0);
    rst = 1'b0;

    // Scenario 1: single job with the maximum load.
    $display("[TB] scenario 1: load 15 on requester 0");
    applyStimulus(4'b0001, '0);
    setLoad(0, 15);
    stepCycle();
    expectValue("t1_grant", int'(bus.grant), 1);
    expectValue("t1_count_start", int'(bus.count), 15);
    for (int j = 14; j >= 0; j--) begin
      stepCycle();
      expectValue("t1_count", int'(bus.count), j);
    end
    stepCycle();
    expectValue("t1_done",  int'(bus.done),  1);
    expectValue("t1_grant_off", int'(bus.grant), 0);
    expectValue("t1_busy_done", int'(bus.busy), 1);
    applyStimulus('0, bus.load_val);
    stepCycle();
    expectValue("t1_busy_idle", int'(bus.busy), 0);
    expectValue("t1_done_off", int'(bus.done), 0);

    // Scenario 2: everyone requesting, fair rotation from a reset pointer.
    $display("[TB] scenario 2: round-robin rotation");
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    applyStimulus(4'b1111, {4'd2, 4'd2, 4'd2, 4'd2});
    for (int j = 0; j < 5; j++) begin
      stepCycle();
      expectValue("t2_grant", int'(bus.grant), int'(t2_exp[j]));
      if (j < 4) begin
        stepCycle();
        stepCycle();
        expectValue("t2_last_count", int'(bus.count), 0);
        stepCycle();
        expectValue("t2_done", int'(bus.done), int'(t2_exp[j]));
        stepCycle();
        expectValue("t2_gap", int'(bus.grant), 0);
      end
    end
    applyStimulus('0, bus.load_val);
    stepCycle();
    stepCycle();

    // Scenario 3: zero load gives one COUNT cycle at 0.
    $display("[TB] scenario 3: zero load");
    applyStimulus(4'b0100, {4'd9, 4'd0, 4'd9, 4'd9});
    stepCycle();
    expectValue("t3_grant", int'(bus.grant), 4);
    expectValue("t3_count", int'(bus.count), 0);
    stepCycle();
    expectValue("t3_done", int'(bus.done), 4);
    applyStimulus('0, bus.load_val);
    stepCycle();

    // Scenario 4: owner abort mid-count, next requester served.
    $display("[TB] scenario 4: abort");
    applyStimulus(4'b0010, {4'd3, 4'd3, 4'd10, 4'd3});
    stepCycle();
    expectValue("t4_grant", int'(bus.grant), 2);
    expectValue("t4_count", int'(bus.count), 10);
    applyStimulus(4'b0110, bus.load_val);
    for (int j = 0; j < 4; j++) stepCycle();
    expectValue("t4_count6", int'(bus.count), 6);
    applyStimulus(4'b0100, bus.load_val);
    stepCycle();
    expectValue("t4_abort_grant", int'(bus.grant), 0);
    expectValue("t4_abort_count", int'(bus.count), 0);
    expectValue("t4_abort_done",  int'(bus.done),  0);
    stepCycle();
    expectValue("t4_next_grant", int'(bus.grant), 4);
    expectValue("t4_next_count", int'(bus.count), 3);
    applyStimulus('0, bus.load_val);
    stepCycle();
    stepCycle();

    // Scenario 5: reset mid-count clears everything and the pointer.
    $display("[TB] scenario 5: reset mid-count");
    applyStimulus(4'b1000, {4'd7, 4'd5, 4'd5, 4'd5});
    stepCycle();
    expectValue("t5_grant", int'(bus.grant), 8);
    expectValue("t5_count", int'(bus.count), 7);
    rst = 1'b1;
    stepCycle();
    expectValue("t5_rst_grant", int'(bus.grant), 0);
    expectValue("t5_rst_count", int'(bus.count), 0);
    expectValue("t5_rst_done",  int'(bus.done),  0);
    rst = 1'b0;
    applyStimulus(4'b1001, bus.load_val);
    stepCycle();
    expectValue("t5_ptr_grant", int'(bus.grant), 1);
    applyStimulus('0, bus.load_val);
    stepCycle();
    stepCycle();

    // Scenario 6: owner holds request through done, re-granted later.
    $display("[TB] scenario 6: hold through done");
    applyStimulus(4'b0001, {4'd0, 4'd0, 4'd0, 4'd1});
    stepCycle();
    expectValue("t6_grant", int'(bus.grant), 1);
    stepCycle();
    stepCycle();
    expectValue("t6_done", int'(bus.done), 1);
    setLoad(0, 3);
    stepCycle();
    expectValue("t6_no_regrant", int'(bus.grant), 0);
    stepCycle();
    expectValue("t6_regrant", int'(bus.grant), 1);
    expectValue("t6_fresh_load", int'(bus.count), 3);
    applyStimulus('0, bus.load_val);
    stepCycle();
    stepCycle();

    // Randomized traffic against the model.
    $display("[TB] random phase");
    for (int c = 0; c < 4000; c++) begin
      randomDrive();
      stepCycle();
    end
    rst = 1'b0;
    applyStimulus('0, bus.load_val);
    for (int c = 0; c < 4; c++) stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
